// File: rtl/uart_temp_pkg.sv
// Shared constants for the temperature-count UART link (transmitter and receiver stages).
package uart_temp_pkg;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_DIGITS, P_EXPECT_CR, P_EXPECT_LF, P_HUNT} parser_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction
endpackage

// File: rtl/uart_temp_line_rx_if.sv
// Parsed-line result bus: the receiver drives it, a consumer listens.
interface uart_temp_line_rx_if #(parameter int NUM_DIGITS = 10);
    logic [4*NUM_DIGITS-1:0] value_bcd_o;
    logic                    value_valid_o;
    logic                    frame_err_o;
    logic                    format_err_o;

    modport master (output value_bcd_o, value_valid_o, frame_err_o, format_err_o);
    modport slave  (input  value_bcd_o, value_valid_o, frame_err_o, format_err_o);
endinterface

// File: rtl/uart_temp_line_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, glitch reject on the start bit.
module uart_rx_byte
    import uart_temp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx_i;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state    <= RX_START;
                        baud_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        // a start bit that is high again at mid-bit was only a glitch
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt  <= '0;
                        data_byte <= {rx_sync, data_byte[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt   <= '0;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                        state      <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_temp_line_rx.sv
// Line parser: NUM_DIGITS ASCII digits + CR LF -> packed BCD value, with error pulses.
module uart_temp_line_rx
    import uart_temp_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int NUM_DIGITS = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                uart_rx_i,
    uart_temp_line_rx_if.master line_if
);
    localparam int DW   = 4 * NUM_DIGITS;
    localparam int CNTW = $clog2(NUM_DIGITS + 1);
    localparam logic [CNTW-1:0] DIGIT_LAST = CNTW'(NUM_DIGITS - 1);

    logic [7:0]      rx_data;
    logic            rx_valid, rx_ferr;
    parser_state_t   pstate;
    logic [CNTW-1:0] dcnt;
    logic [DW-1:0]   shreg;
    logic            is_digit, byte_ok;

    uart_rx_byte #(.CLKS_PER_BIT(clks_per_bit(CLK_FREQ, BAUD_RATE))) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_i      (uart_rx_i),
        .data_byte (rx_data),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    assign is_digit = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);

    always_comb begin
        byte_ok = 1'b1;
        case (pstate)
            P_DIGITS:    byte_ok = is_digit;
            P_EXPECT_CR: byte_ok = (rx_data == ASCII_CR);
            P_EXPECT_LF: byte_ok = (rx_data == ASCII_LF);
            default:     byte_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pstate                <= P_DIGITS;
            dcnt                  <= '0;
            shreg                 <= '0;
            line_if.value_bcd_o   <= '0;
            line_if.value_valid_o <= 1'b0;
            line_if.format_err_o  <= 1'b0;
            line_if.frame_err_o   <= 1'b0;
        end else begin
            line_if.value_valid_o <= 1'b0;
            line_if.format_err_o  <= 1'b0;
            line_if.frame_err_o   <= 1'b0;
            if (rx_ferr) begin
                line_if.frame_err_o <= 1'b1;
                dcnt                <= '0;
                pstate              <= P_HUNT;
            end else if (rx_valid && !byte_ok) begin
                line_if.format_err_o <= 1'b1;
                dcnt                 <= '0;
                pstate               <= P_HUNT;
            end else if (rx_valid) begin
                case (pstate)
                    P_DIGITS: begin
                        // low nibble of '0'..'9' is the digit value
                        shreg <= {shreg[DW-5:0], rx_data[3:0]};
                        dcnt  <= dcnt + 1'b1;
                        if (dcnt == DIGIT_LAST) pstate <= P_EXPECT_CR;
                    end
                    P_EXPECT_CR: pstate <= P_EXPECT_LF;
                    P_EXPECT_LF: begin
                        line_if.value_bcd_o   <= shreg;
                        line_if.value_valid_o <= 1'b1;
                        dcnt                  <= '0;
                        pstate                <= P_DIGITS;
                    end
                    default: begin
                        if (rx_data == ASCII_LF) begin
                            dcnt   <= '0;
                            pstate <= P_DIGITS;
                        end
                    end
                endcase
            end
        end
    end
endmodule
